// File: rtl/spi_slave_param_if.sv
// Bus bundle for spi_slave_param: SPI pins, tx buffer write port and rx handshake.
interface spi_slave_param_if #(
   parameter int DATA_W = 11
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic              SCK;
   logic              SS_n;
   logic              SDI;
   logic              SDO;
   logic              SDO_En;
   logic [DATA_W-1:0] TxData;
   logic              TxLoad;
   logic              TxReady;
   logic [DATA_W-1:0] DataOut;
   logic              SSPIF;
   logic              RxValid;
   logic              RxAck;
   logic              Overrun;
   logic [CNT_W-1:0]  BitCnt;

   modport slave (
      input  SCK, SS_n, SDI, TxData, TxLoad, RxAck,
      output SDO, SDO_En, TxReady, DataOut, SSPIF, RxValid, Overrun, BitCnt
   );

   modport master (
      output SCK, SS_n, SDI, TxData, TxLoad, RxAck,
      input  SDO, SDO_En, TxReady, DataOut, SSPIF, RxValid, Overrun, BitCnt
   );
endinterface

// File: rtl/spi_slave_param.sv
// Oversampled full-duplex SPI slave, any CPOL/CPHA, configurable width and bit order,
// one-word tx buffer and valid/ack rx handshake with overrun flag.
module spi_slave_param #(
   parameter int DATA_W      = 11,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   spi_slave_param_if.slave bus
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;

   logic [1:0] rst_pipe_q;
   logic       rst_n;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) rst_pipe_q <= '0;
      else        rst_pipe_q <= {rst_pipe_q[0], 1'b1};
   end
   assign rst_n = rst_pipe_q[1];

   logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, sdi_sync_q;
   logic sck_prev_q, ss_prev_q, sample_q, shift_q, sdi_cap_q;
   logic sck_s, ss_s, rise, fall, lead, trail;

   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign ss_s  = ss_sync_q[SYNC_STAGES-1];
   assign rise  = sck_s & ~sck_prev_q;
   assign fall  = ~sck_s & sck_prev_q;
   assign lead  = (CPOL != 0) ? fall : rise;
   assign trail = (CPOL != 0) ? rise : fall;

   // Edge pulses and the SDI value are registered together so they stay aligned.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q <= (CPOL != 0) ? '1 : '0;
         ss_sync_q  <= '1;
         sdi_sync_q <= '0;
         sck_prev_q <= (CPOL != 0);
         ss_prev_q  <= 1'b1;
         sample_q   <= 1'b0;
         shift_q    <= 1'b0;
         sdi_cap_q  <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
         ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS_n};
         sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.SDI};
         sck_prev_q <= sck_s;
         ss_prev_q  <= ss_s;
         sample_q   <= (CPHA != 0) ? trail : lead;
         shift_q    <= (CPHA != 0) ? lead : trail;
         sdi_cap_q  <= sdi_sync_q[SYNC_STAGES-1];
      end
   end

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rx_q, rx_d, tx_q, tx_d, buf_q, buf_d, dout_q, dout_d;
   logic              full_q, full_d, sdo_q, sdo_d, sspif_q, sspif_d;
   logic              valid_q, valid_d, ovr_q, ovr_d;
   logic              complete, reload, tx_first;
   logic [DATA_W-1:0] rx_next, load_word, tx_src, tx_adv;

   always_comb begin
      rx_next   = (MSB_FIRST != 0) ? {rx_q[DATA_W-2:0], sdi_cap_q}
                                   : {sdi_cap_q, rx_q[DATA_W-1:1]};
      complete  = (state_q == SHIFT) && !ss_s && sample_q && (cnt_q == LAST_BIT);
      reload    = (state_q == LOAD) || complete;
      load_word = full_q ? buf_q : '0;
      // tx_q holds only bits not yet driven onto SDO; presenting a bit pops it.
      tx_src    = (state_q == LOAD) ? load_word : tx_q;
      tx_first  = (MSB_FIRST != 0) ? tx_src[DATA_W-1] : tx_src[0];
      tx_adv    = (MSB_FIRST != 0) ? {tx_src[DATA_W-2:0], 1'b0}
                                   : {1'b0, tx_src[DATA_W-1:1]};

      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      sdo_d   = sdo_q;
      dout_d  = complete ? rx_next : dout_q;
      sspif_d = complete;
      valid_d = complete | (valid_q & ~bus.RxAck);
      ovr_d   = bus.RxAck ? 1'b0 : (ovr_q | (complete & valid_q));
      buf_d   = buf_q;
      full_d  = full_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            rx_d  = '0;
            if (!ss_s && ss_prev_q) state_d = LOAD;
         end
         LOAD: begin
            if (CPHA == 0) begin
               sdo_d = tx_first;
               tx_d  = tx_adv;
            end else begin
               tx_d  = load_word;
            end
            state_d = ss_s ? IDLE : SHIFT;
         end
         SHIFT: begin
            if (ss_s) begin
               state_d = IDLE;
               cnt_d   = '0;
               rx_d    = '0;
            end else begin
               if (sample_q) begin
                  if (complete) begin
                     cnt_d = '0;
                     rx_d  = '0;
                     tx_d  = load_word;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                     rx_d  = rx_next;
                  end
               end
               if (shift_q) begin
                  sdo_d = tx_first;
                  tx_d  = tx_adv;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (reload && full_q) full_d = 1'b0;
      else if (bus.TxLoad && !full_q) begin
         buf_d  = bus.TxData;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         buf_q   <= '0;
         dout_q  <= '0;
         full_q  <= 1'b0;
         sdo_q   <= 1'b0;
         sspif_q <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         buf_q   <= buf_d;
         dout_q  <= dout_d;
         full_q  <= full_d;
         sdo_q   <= sdo_d;
         sspif_q <= sspif_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.SDO     = sdo_q;
   assign bus.SDO_En  = (state_q != IDLE);
   assign bus.TxReady = ~full_q;
   assign bus.DataOut = dout_q;
   assign bus.SSPIF   = sspif_q;
   assign bus.RxValid = valid_q;
   assign bus.Overrun = ovr_q;
   assign bus.BitCnt  = cnt_q;
endmodule
